kuznechik_key_store: RTL and testbench

- Storage and read-out block for the Kuznechik key schedule: 10 × 128-bit round keys.
- Write side is driven directly by the key generator's pair-strobe interface: a 256-bit bus plus a one-cycle ready pulse, five pulses per schedule.
- Read side serves the cipher datapath one round key per accepted handshake, in forward order (encrypt) or reverse order (decrypt).
- Sits between the key generator and the round engine, so the engine never sees the 256-bit pair format.

---
 rtl/kuznechik_key_store.sv | 139 +++++++++++++
 tb/tb_kuznechik_key_store.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/kuznechik_key_store.sv
// Kuznechik round-key store: captures five 256-bit key pairs from the key
// generator into a 10 x 128-bit register array, then streams the round keys
// to the cipher datapath in forward (encrypt) or reverse (decrypt) order.
module kuznechik_key_store #(
  parameter int NKEYS = 10,
  parameter int KW    = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic          kg_ready,
  input  logic [2*KW-1:0] kg_keys,
  input  logic          req,
  input  logic          decrypt,
  input  logic          key_ack,
  output logic [KW-1:0] key_out,
  output logic          key_valid,
  output logic [3:0]    key_idx,
  output logic          key_last,
  output logic          keys_loaded,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, LOAD, READY, STREAM} state_t;

  state_t        state_q, state_d;
  logic [2:0]    pair_cnt_q, pair_cnt_d;
  logic          dec_q, dec_d;
  logic [KW-1:0] key_out_q, key_out_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    key_idx_q, key_idx_d;
  logic          key_last_q, key_last_d;
  logic          loaded_q, loaded_d;
  logic          busy_q, busy_d;
  logic          we;

  // Key array has no reset: keys_loaded = 0 makes its contents unusable.
  logic [KW-1:0] mem_q [NKEYS];

  // Next-state, write-enable and registered output values.
  always_comb begin
    state_d     = state_q;
    pair_cnt_d  = pair_cnt_q;
    dec_d       = dec_q;
    key_out_d   = key_out_q;
    key_valid_d = key_valid_q;
    key_idx_d   = key_idx_q;
    key_last_d  = key_last_q;
    loaded_d    = loaded_q;
    we          = 1'b0;
    if (load_start) begin
      // Restart capture from any state; a running stream is dropped.
      state_d     = LOAD;
      pair_cnt_d  = 3'd0;
      loaded_d    = 1'b0;
      key_valid_d = 1'b0;
      key_last_d  = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (kg_ready) begin
            we         = 1'b1;
            pair_cnt_d = pair_cnt_q + 3'd1;
            if (pair_cnt_q == 3'd4) begin
              state_d  = READY;
              loaded_d = 1'b1;
            end
          end
        end
        READY: begin
          if (req) begin
            state_d     = STREAM;
            dec_d       = decrypt;
            key_idx_d   = decrypt ? 4'd9 : 4'd0;
            key_out_d   = mem_q[key_idx_d];
            key_valid_d = 1'b1;
            key_last_d  = 1'b0;
          end
        end
        STREAM: begin
          if (key_valid_q && key_ack) begin
            if (key_last_q) begin
              state_d     = READY;
              key_valid_d = 1'b0;
              key_last_d  = 1'b0;
            end else begin
              key_idx_d  = dec_q ? key_idx_q - 4'd1 : key_idx_q + 4'd1;
              key_out_d  = mem_q[key_idx_d];
              key_last_d = dec_q ? (key_idx_d == 4'd0) : (key_idx_d == 4'd9);
            end
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d == LOAD) || (state_d == STREAM);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pair_cnt_q  <= 3'd0;
      dec_q       <= 1'b0;
      key_out_q   <= '0;
      key_valid_q <= 1'b0;
      key_idx_q   <= 4'd0;
      key_last_q  <= 1'b0;
      loaded_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pair_cnt_q  <= pair_cnt_d;
      dec_q       <= dec_d;
      key_out_q   <= key_out_d;
      key_valid_q <= key_valid_d;
      key_idx_q   <= key_idx_d;
      key_last_q  <= key_last_d;
      loaded_q    <= loaded_d;
      busy_q      <= busy_d;
    end
  end

  // Pair write: upper half is the odd key K(2p+1), lower half K(2p+2).
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[{pair_cnt_q, 1'b0}] <= kg_keys[2*KW-1:KW];
      mem_q[{pair_cnt_q, 1'b1}] <= kg_keys[KW-1:0];
    end
  end

  assign key_out     = key_out_q;
  assign key_valid   = key_valid_q;
  assign key_idx     = key_idx_q;
  assign key_last    = key_last_q;
  assign keys_loaded = loaded_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_kuznechik_key_store.sv
// Directed bench for kuznechik_key_store: a table of per-cycle vectors for
// the basic load/encrypt flow, plus hand-written multi-cycle sequences.
module tb_kuznechik_key_store;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load_start = 1'b0;
  logic         kg_ready = 1'b0;
  logic [255:0] kg_keys = '0;
  logic         req = 1'b0;
  logic         decrypt = 1'b0;
  logic         key_ack = 1'b0;
  logic [127:0] key_out;
  logic         key_valid;
  logic [3:0]   key_idx;
  logic         key_last;
  logic         keys_loaded;
  logic         busy;

  int nvec = 0;
  int nerr = 0;

  kuznechik_key_store dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .kg_ready(kg_ready),
    .kg_keys(kg_keys), .req(req), .decrypt(decrypt), .key_ack(key_ack),
    .key_out(key_out), .key_valid(key_valid), .key_idx(key_idx),
    .key_last(key_last), .keys_loaded(keys_loaded), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ls, kr; int pair; logic rq, dc, ack;
    logic ev; int ei; logic el, eld, eb;
  } vec_t;

  vec_t vq[$];

  function automatic logic [127:0] kn(input int n);
    logic [7:0] b;
    b = n[7:0];
    return {16{b}};
  endfunction

  function automatic logic [255:0] pair_data(input int p);
    return {kn(2*p+1), kn(2*p+2)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic add(input logic ls, kr, input int pair, input logic rq, dc, ack,
                     input logic ev, input int ei, input logic el, eld, eb);
    vec_t v;
    v = '{ls, kr, pair, rq, dc, ack, ev, ei, el, eld, eb};
    vq.push_back(v);
  endtask

  task automatic pulse_pair(input logic [255:0] d);
    kg_keys = d; kg_ready = 1'b1; step();
    kg_ready = 1'b0; step(); step();
  endtask

  task automatic do_load();
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int p = 0; p < 5; p++) pulse_pair(pair_data(p));
  endtask

  // Stream a full schedule; mode 0 holds ack high, mode 1 acks every 3rd cycle.
  task automatic run_stream(input logic dec, input int mode, input string tag);
    int e, n, cyc;
    bit done;
    req = 1'b1; decrypt = dec; step(); req = 1'b0; decrypt = 1'b0;
    e = dec ? 9 : 0; n = 0; done = 0; cyc = 0;
    while (cyc < 60 && !done) begin
      key_ack = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      chk({tag, " valid"}, 128'(key_valid), 128'(1));
      chk({tag, " idx"}, 128'(key_idx), 128'(e[3:0]));
      chk({tag, " key"}, key_out, kn(e + 1));
      chk({tag, " last"}, 128'(key_last), 128'(e == (dec ? 0 : 9)));
      step();
      cyc++;
      if (key_ack) begin
        n++;
        if (n == 10) done = 1;
        else e = dec ? e - 1 : e + 1;
      end
    end
    key_ack = 1'b0;
    if (!done) chk({tag, " timeout"}, 128'(n), 128'(10));
    if (mode == 0) chk({tag, " cycles"}, 128'(cyc), 128'(10));
    chk({tag, " end valid"}, 128'(key_valid), 128'(0));
    chk({tag, " end last"}, 128'(key_last), 128'(0));
    chk({tag, " end busy"}, 128'(busy), 128'(0));
    chk({tag, " end loaded"}, 128'(keys_loaded), 128'(1));
  endtask

  initial begin
    // Table: reset state, load of 5 pairs spaced 3 cycles, encrypt with ack held.
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    for (int p = 0; p < 5; p++) begin
      add(0, 1, p, 0, 0, 0,  0, 0, 0, p == 4, p < 4);
      add(0, 0, 0, 0, 0, 0,  0, 0, 0, p == 4, p < 4);
      add(0, 0, 0, 0, 0, 0,  0, 0, 0, p == 4, p < 4);
    end
    add(0, 0, 0, 1, 0, 0,  1, 0, 0, 1, 1);
    for (int k = 0; k < 10; k++)
      add(0, 0, 0, 0, 0, 1,  k < 9, k + 1, k == 8, 1, k < 9);

    step(); step();
    chk("reset key_out", key_out, 128'(0));
    chk("reset idx", 128'(key_idx), 128'(0));
    rst_n = 1'b1;
    step();

    foreach (vq[i]) begin
      load_start = vq[i].ls; kg_ready = vq[i].kr; kg_keys = pair_data(vq[i].pair);
      req = vq[i].rq; decrypt = vq[i].dc; key_ack = vq[i].ack;
      step();
      chk($sformatf("vec%0d valid", i), 128'(key_valid), 128'(vq[i].ev));
      chk($sformatf("vec%0d last", i), 128'(key_last), 128'(vq[i].el));
      chk($sformatf("vec%0d loaded", i), 128'(keys_loaded), 128'(vq[i].eld));
      chk($sformatf("vec%0d busy", i), 128'(busy), 128'(vq[i].eb));
      if (vq[i].ev) begin
        chk($sformatf("vec%0d idx", i), 128'(key_idx), 128'(vq[i].ei));
        chk($sformatf("vec%0d key", i), key_out, kn(vq[i].ei + 1));
      end
    end
    load_start = 0; kg_ready = 0; req = 0; decrypt = 0; key_ack = 0;
    step();

    // Decrypt order, twice on the same schedule.
    run_stream(1'b1, 0, "dec1");
    step();
    run_stream(1'b1, 0, "dec2");

    // Back-pressure on an encrypt stream.
    run_stream(1'b0, 1, "bp");

    // Abort at key_idx 4 by load_start (ack high in the same cycle).
    req = 1'b1; step(); req = 1'b0; key_ack = 1'b1;
    for (int c = 0; c < 20 && key_idx != 4'd4; c++) step();
    chk("abort reach idx4", 128'(key_idx), 128'(4));
    load_start = 1'b1; step(); load_start = 1'b0; key_ack = 1'b0;
    chk("abort valid", 128'(key_valid), 128'(0));
    chk("abort loaded", 128'(keys_loaded), 128'(0));
    chk("abort busy", 128'(busy), 128'(1));
    // req with only 2 pairs captured is ignored.
    pulse_pair(pair_data(0));
    pulse_pair(pair_data(1));
    req = 1'b1; step(); req = 1'b0; step();
    chk("early req valid", 128'(key_valid), 128'(0));
    chk("early req loaded", 128'(keys_loaded), 128'(0));
    for (int p = 2; p < 5; p++) pulse_pair(pair_data(p));
    chk("reload loaded", 128'(keys_loaded), 128'(1));
    // A 6th pair after READY must not overwrite anything.
    pulse_pair({kn(8'hEE), kn(8'hEF)});
    run_stream(1'b0, 0, "6th");

    // Asynchronous reset mid-load.
    load_start = 1'b1; step(); load_start = 1'b0;
    pulse_pair(pair_data(0));
    pulse_pair(pair_data(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", 128'(busy), 128'(0));
    chk("async rst loaded", 128'(keys_loaded), 128'(0));
    chk("async rst valid", 128'(key_valid), 128'(0));
    chk("async rst key", key_out, 128'(0));
    @(negedge clk) rst_n = 1'b1;
    step();
    req = 1'b1; step(); req = 1'b0; step();
    chk("idle req valid", 128'(key_valid), 128'(0));
    chk("idle req busy", 128'(busy), 128'(0));
    do_load();
    run_stream(1'b0, 0, "post-rst");

    // load_start together with kg_ready: that pair is dropped.
    load_start = 1'b1; kg_ready = 1'b1; kg_keys = {kn(8'h77), kn(8'h78)};
    step();
    load_start = 1'b0; kg_ready = 1'b0;
    step();
    chk("simul loaded", 128'(keys_loaded), 128'(0));
    for (int p = 0; p < 5; p++) pulse_pair(pair_data(p));
    chk("simul loaded5", 128'(keys_loaded), 128'(1));
    run_stream(1'b0, 0, "simul");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
